deskew_collector: RTL and testbench
===================================

# deskew_collector

Output-side counterpart of the input skew buffer. The systolic array produces result rows in skewed form: lane c of a word arrives c cycles after lane 0. This block realigns the lanes with a triangular delay, where lane c is delayed by Size-1-c cycles. It then queues aligned words in a FIFO and presents them as an AXI-Stream master with tlast framing. Credit-style `in_ready_o` lets the non-stallable array know when it may launch a word.

## Interface
- Width, 8, bits per lane
- Size, 4, number of lanes (array columns); must be ≥ 1
- Depth, 8, output FIFO entries; must be ≥ Size+1 for full throughput (power of two not required)
- Frame, 4, words per AXI-Stream frame; tlast is asserted on word Frame-1 of each frame
- clk_i  in  1  clock; all logic on rising edge
- rst_i  in  1  reset, synchronous, active-high
- valid_i  in  1  marks the cycle in which lane 0 of a new word is on `x_i[0]`
- x_i  in  Size×Width  skewed lane data; lane c of the word launched at cycle t is sampled at cycle t+c
- in_ready_o  out  1  credit; upstream may assert `valid_i` only in a cycle where this is 1
- overflow_o  out  1  sticky error; a word was launched without credit
- m_axis_tdata_o  out  Size×Width  aligned word; lane c at bits [c*Width +: Width]
- m_axis_tvalid_o  out  1  AXI-Stream valid
- m_axis_tlast_o  out  1  last word of frame
- m_axis_tready_i  in  1  AXI-Stream ready

## Operation
- Deskew triangle:
  - Lane c passes through Size-1-c registers. Lane Size-1 is combinational.
  - Deskew registers shift every cycle; they are not gated by `valid_i` or backpressure.
  - Each deskew register is reset to 0.
- Valid pipeline:
  - A (Size-1)-stage shift register carries `valid_i`.
  - Its output, `wr_v`, is high in cycle t+Size-1 for a word launched at t.
  - For Size=1, `wr_v` = `valid_i`.
- FIFO write:
  - When `wr_v`=1, the aligned word {lane c from deskew} plus a tlast bit is written.
  - If the FIFO is full and no pop occurs in the same cycle, the word is dropped and `overflow_o` is set.
  - A simultaneous pop and push on a full FIFO succeeds.
- Frame counter:
  - Counts written words in the range 0..Frame-1.
  - tlast bit = (count == Frame-1).
  - Increments only on a successful write and wraps to 0 after Frame-1.
  - Dropped words do not advance it.
- FIFO read: a pop occurs when `m_axis_tvalid_o` && `m_axis_tready_i`.
- Output signals:
  - `m_axis_tvalid_o` = FIFO not empty.
  - Data and last come from the head entry.
  - Data and last are held stable while valid && !ready.
- Credit:
  - inflight = popcount of the valid shift register, counting words launched but not yet written.
  - `in_ready_o` = !rst_i && (inflight + fifo_count < Depth).
  - This guarantees no drop when upstream obeys the credit.
- `overflow_o`: sticky; set on any drop; cleared only by reset.
- Reset values: deskew regs, valid pipe, FIFO pointers and count, frame counter, and `overflow_o` all 0.
  - Consequently `m_axis_tvalid_o`=0, `m_axis_tlast_o`=0, `m_axis_tdata_o`=0 (head entry also reset).
  - `in_ready_o`=0 while `rst_i`=1.
- Reset mid-operation: all in-flight and queued words are discarded. No partial word is emitted after reset.

## Timing
- Word launched at cycle t (`valid_i`=1 with `x_i[0]`):
  - Written at the edge ending cycle t+Size-1.
  - `m_axis_tvalid_o`=1 in cycle t+Size if the FIFO was empty. Latency is Size cycles.
- Throughput: one word per cycle sustained when tready is held at 1 and Depth ≥ Size+1.
- `in_ready_o` is combinational from registered state, with no dependence on `valid_i` in the same cycle.
- A pop in cycle n frees credit visible in cycle n+1.

## Test plan
- Single word, Size=4, Width=8:
  - Stimulus: valid_i at t=10 with lane0=0x11, lane1=0x22 at t=11, lane2=0x33 at t=12, lane3=0x44 at t=13, tready=1.
  - Required: tvalid=1 only in cycle 14, tdata=0x44332211, tlast=0.
- Streaming, Frame=4: launch 8 back-to-back words with lane c of word k = 16k+c and tready=1.
  - Required: 8 consecutive tvalid cycles starting 4 cycles after the first launch, data matching, tlast on words 3 and 7, `overflow_o`=0.
- Backpressure, Depth=8: hold tready=0 and launch whenever `in_ready_o`=1.
  - Required: exactly 8 words launched, then `in_ready_o`=0.
  - Then raise tready: all 8 words drain in order, and `in_ready_o` returns to 1 the cycle after the first pop.
- Credit violation:
  - Stimulus: fill the FIFO with tready=0, then force one extra valid_i.
  - Required: `overflow_o` rises in cycle launch+3 and stays 1; the FIFO contents are unchanged; the frame counter is not advanced.
- Full push+pop:
  - Stimulus: FIFO full with credit-legal launches, tready=1 in the same cycle a word lands.
  - Required: no drop, count stays 8, order preserved.
- Reset mid-stream:
  - Stimulus: assert rst_i for 1 cycle with 3 words in flight and 2 queued.
  - Required: the next cycle has tvalid=0, `in_ready_o`=1, and `overflow_o`=0; no stale words ever appear.

Source files
------------

// File: rtl/deskew_collector.sv
// deskew_collector: realigns skewed systolic-array result lanes with a
// triangular delay, queues aligned words in a FIFO and presents them as an
// AXI-Stream master with tlast framing. in_ready_o is a credit that keeps
// the non-stallable array from overrunning the FIFO.
module deskew_collector #(
    parameter int Width = 8,
    parameter int Size  = 4,
    parameter int Depth = 8,
    parameter int Frame = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    input  logic [Size*Width-1:0] x_i,
    output logic                  in_ready_o,
    output logic                  overflow_o,
    output logic [Size*Width-1:0] m_axis_tdata_o,
    output logic                  m_axis_tvalid_o,
    output logic                  m_axis_tlast_o,
    input  logic                  m_axis_tready_i
);

    localparam int EntryW = Size * Width + 1;
    localparam int PtrW   = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW   = $clog2(Depth + 1);
    localparam int FrmW   = (Frame > 1) ? $clog2(Frame) : 1;
    localparam int unsigned DepthU = Depth;

    logic [Size-1:0][Width-1:0] aligned;
    logic                       wr_v;
    int unsigned                inflight;
    int unsigned                occupancy;

    logic [EntryW-1:0] mem [Depth];
    logic [EntryW-1:0] head;
    logic [PtrW-1:0]   wr_ptr;
    logic [PtrW-1:0]   rd_ptr;
    logic [CntW-1:0]   count;
    logic [FrmW-1:0]   frame_cnt;
    logic              ovf_q;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;
    logic              last_bit;

    function automatic logic [PtrW-1:0] ptr_next(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    // Deskew triangle: lane c is delayed by Size-1-c cycles, last lane passes straight through.
    for (genvar c = 0; c < Size; c++) begin : g_lane
        localparam int Dly = Size - 1 - c;
        if (Dly == 0) begin : g_pass
            assign aligned[c] = x_i[c*Width +: Width];
        end else begin : g_dly
            logic [Dly*Width-1:0] sr;

            // Free-running lane delay line, never gated by valid or backpressure.
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << Width) | (Dly*Width)'(x_i[c*Width +: Width]);
                end
            end

            assign aligned[c] = sr[Dly*Width-1 -: Width];
        end
    end

    // Valid pipeline matches the deskew latency; its popcount is the in-flight word count.
    if (Size > 1) begin : g_vpipe
        logic [Size-2:0] vpipe;

        // Shift valid_i alongside lane 0 of each word.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vpipe <= '0;
            end else begin
                vpipe <= (vpipe << 1) | (Size-1)'(valid_i);
            end
        end

        assign wr_v     = vpipe[Size-2];
        assign inflight = $countones(vpipe);
    end else begin : g_novpipe
        assign wr_v     = valid_i;
        assign inflight = '0;
    end

    assign full     = (count == CntW'(Depth));
    assign pop      = (count != '0) && m_axis_tready_i;
    assign push     = wr_v && (!full || pop);
    assign drop     = wr_v && full && !pop;
    assign last_bit = (frame_cnt == FrmW'(Frame - 1));

    // FIFO storage, pointers and occupancy; head entry is reset so outputs read 0 out of reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mem    <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= {last_bit, aligned};
                wr_ptr      <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + CntW'(1);
                2'b01:   count <= count - CntW'(1);
                default: count <= count;
            endcase
        end
    end

    // Frame position of the next written word; dropped words leave it untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            frame_cnt <= '0;
        end else if (push) begin
            frame_cnt <= last_bit ? '0 : frame_cnt + FrmW'(1);
        end
    end

    // Sticky overflow record, cleared only by reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_q <= 1'b0;
        end else if (drop) begin
            ovf_q <= 1'b1;
        end
    end

    // Flag is visible in the very cycle the drop happens, then held by ovf_q.
    assign overflow_o = ovf_q || (drop && !rst_i);

    assign occupancy  = inflight + 32'(count);
    assign in_ready_o = !rst_i && (occupancy < DepthU);

    assign head            = mem[rd_ptr];
    assign m_axis_tvalid_o = (count != '0);
    assign m_axis_tdata_o  = head[Size*Width-1:0];
    assign m_axis_tlast_o  = head[EntryW-1];

endmodule

// File: tb/tb_deskew_collector.sv
// Self-checking bench for deskew_collector (Width=8, Size=4, Depth=8, Frame=4).
// The bench skews each launched word itself: lane c of a word appears on x_i
// c cycles after its launch.
module tb_deskew_collector;

    localparam int W = 8;
    localparam int S = 4;
    localparam int D = 8;
    localparam int F = 4;

    logic           clk = 1'b0;
    logic           rst_i;
    logic           valid_i;
    logic [S*W-1:0] x_i;
    logic           in_ready_o;
    logic           overflow_o;
    logic [S*W-1:0] m_axis_tdata_o;
    logic           m_axis_tvalid_o;
    logic           m_axis_tlast_o;
    logic           m_axis_tready_i;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    logic [S*W-1:0] hist [S];

    typedef struct {
        bit             valid;
        logic [S*W-1:0] word;
        bit             exp_tvalid;
        logic [S*W-1:0] exp_tdata;
        bit             exp_tlast;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    deskew_collector #(
        .Width(W),
        .Size (S),
        .Depth(D),
        .Frame(F)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .valid_i        (valid_i),
        .x_i            (x_i),
        .in_ready_o     (in_ready_o),
        .overflow_o     (overflow_o),
        .m_axis_tdata_o (m_axis_tdata_o),
        .m_axis_tvalid_o(m_axis_tvalid_o),
        .m_axis_tlast_o (m_axis_tlast_o),
        .m_axis_tready_i(m_axis_tready_i)
    );

    function automatic logic [S*W-1:0] word_of(input int k);
        logic [S*W-1:0] w;
        for (int c = 0; c < S; c++) w[c*W +: W] = 8'(16 * k + c);
        return w;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: apply rst/tready, optionally gate the launch on credit, drive skewed lanes.
    task automatic step(input bit rst, input bit v, input logic [S*W-1:0] w,
                        input bit rdy, input bit gate, output bit launched);
        @(posedge clk);
        #1;
        rst_i           = rst;
        m_axis_tready_i = rdy;
        #1;
        launched = v && (!gate || in_ready_o);
        for (int c = S - 1; c > 0; c--) hist[c] = hist[c-1];
        hist[0] = launched ? w : '0;
        valid_i = launched;
        for (int c = 0; c < S; c++) x_i[c*W +: W] = hist[c][c*W +: W];
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bit l;
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, l);
    endtask

    // Launch on credit with tready low until the FIFO is full.
    task automatic fill(input int base, input string name);
        bit l;
        int n;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, word_of(base + n), 1'b0, 1'b1, l);
            if (l) n++;
        end
        chk({name, "_launches"}, 32'(n), 32'd8);
        chk({name, "_ready_full"}, 32'(in_ready_o), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        bit l;
        logic [S*W-1:0] exp_q [$];
        logic [S*W-1:0] extra;

        rst_i           = 1'b1;
        valid_i         = 1'b0;
        x_i             = '0;
        m_axis_tready_i = 1'b0;
        for (int c = 0; c < S; c++) hist[c] = '0;

        for (int i = 0; i < 16; i++) begin
            vecs[i].valid      = (i < 8);
            vecs[i].word       = word_of(i);
            vecs[i].exp_tvalid = (i >= 4) && (i < 12);
            vecs[i].exp_tdata  = word_of(i - 4);
            vecs[i].exp_tlast  = (i >= 4) && (i < 12) && (((i - 4) % 4) == 3);
        end

        // Reset state
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, l);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, l);
        chk("rst_in_ready", 32'(in_ready_o), 32'd0);
        chk("rst_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        chk("rst_tlast", 32'(m_axis_tlast_o), 32'd0);
        chk("rst_tdata", 32'(m_axis_tdata_o), 32'd0);
        chk("rst_overflow", 32'(overflow_o), 32'd0);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, l);
        chk("post_rst_in_ready", 32'(in_ready_o), 32'd1);

        // Single word: tvalid only 4 cycles after launch
        do_reset();
        for (int i = 0; i < 9; i++) begin
            step(1'b0, (i == 0), 32'h44332211, 1'b1, 1'b0, l);
            chk("single_tvalid", 32'(m_axis_tvalid_o), 32'(i == 4));
            if (i == 4) begin
                chk("single_tdata", m_axis_tdata_o, 32'h44332211);
                chk("single_tlast", 32'(m_axis_tlast_o), 32'd0);
            end
        end

        // Streaming table: 8 back-to-back words, tready held high
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(1'b0, vecs[i].valid, vecs[i].word, 1'b1, 1'b0, l);
            chk("stream_tvalid", 32'(m_axis_tvalid_o), 32'(vecs[i].exp_tvalid));
            if (vecs[i].exp_tvalid) begin
                chk("stream_tdata", m_axis_tdata_o, vecs[i].exp_tdata);
                chk("stream_tlast", 32'(m_axis_tlast_o), 32'(vecs[i].exp_tlast));
            end
            chk("stream_in_ready", 32'(in_ready_o), 32'd1);
            chk("stream_overflow", 32'(overflow_o), 32'd0);
        end

        // Backpressure: fill on credit, then drain in order
        do_reset();
        fill(8, "bp");
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
            if (k == 0) chk("bp_ready_first_pop", 32'(in_ready_o), 32'd0);
            if (k == 1) chk("bp_ready_after_pop", 32'(in_ready_o), 32'd1);
            chk("bp_tvalid", 32'(m_axis_tvalid_o), 32'd1);
            chk("bp_tdata", m_axis_tdata_o, word_of(8 + k));
            chk("bp_tlast", 32'(m_axis_tlast_o), 32'((k % 4) == 3));
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
        chk("bp_empty", 32'(m_axis_tvalid_o), 32'd0);
        chk("bp_overflow", 32'(overflow_o), 32'd0);

        // Full push+pop: an extra word lands on a full FIFO in the same cycle as a pop
        do_reset();
        fill(80, "pp");
        extra = 32'h0BADF00D;
        step(1'b0, 1'b1, extra, 1'b0, 1'b0, l);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, l);
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, l);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
        chk("pp_no_drop", 32'(overflow_o), 32'd0);
        chk("pp_head_before", m_axis_tdata_o, word_of(80));
        step(1'b0, 1'b0, '0, 1'b0, 1'b0, l);
        chk("pp_still_full", 32'(in_ready_o), 32'd0);
        chk("pp_tvalid", 32'(m_axis_tvalid_o), 32'd1);
        exp_q = {};
        for (int k = 1; k < 8; k++) exp_q.push_back(word_of(80 + k));
        exp_q.push_back(extra);
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
            chk("pp_tvalid_drain", 32'(m_axis_tvalid_o), 32'd1);
            chk("pp_tdata", m_axis_tdata_o, exp_q[k]);
            chk("pp_tlast", 32'(m_axis_tlast_o), 32'((k == 2) || (k == 6)));
        end
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
        chk("pp_empty", 32'(m_axis_tvalid_o), 32'd0);
        chk("pp_overflow_end", 32'(overflow_o), 32'd0);

        // Credit violation: extra launch on a full FIFO is dropped
        do_reset();
        fill(20, "cv");
        for (int j = 0; j < 6; j++) begin
            step(1'b0, (j == 0), 32'hDEADBEEF, 1'b0, 1'b0, l);
            chk("cv_overflow", 32'(overflow_o), 32'(j >= 3));
            chk("cv_head", m_axis_tdata_o, word_of(20));
        end
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
            chk("cv_tdata", m_axis_tdata_o, word_of(20 + k));
            chk("cv_tlast", 32'(m_axis_tlast_o), 32'((k % 4) == 3));
            chk("cv_sticky", 32'(overflow_o), 32'd1);
        end
        // Frame counter must not have moved on the dropped word
        for (int i = 0; i < 10; i++) begin
            step(1'b0, (i < 4), word_of(40 + i), 1'b1, 1'b0, l);
            chk("cv_post_tvalid", 32'(m_axis_tvalid_o), 32'((i >= 4) && (i < 8)));
            if ((i >= 4) && (i < 8)) begin
                chk("cv_post_tdata", m_axis_tdata_o, word_of(40 + i - 4));
                chk("cv_post_tlast", 32'(m_axis_tlast_o), 32'(i == 7));
            end
        end
        chk("cv_sticky_end", 32'(overflow_o), 32'd1);

        // Reset mid-stream: 2 queued, 3 in flight, overflow still set from above
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, word_of(60 + i), 1'b0, 1'b0, l);
        end
        chk("mid_queued", 32'(m_axis_tvalid_o), 32'd1);
        step(1'b1, 1'b0, '0, 1'b0, 1'b0, l);
        chk("mid_rst_ready", 32'(in_ready_o), 32'd0);
        step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
        chk("mid_tvalid", 32'(m_axis_tvalid_o), 32'd0);
        chk("mid_in_ready", 32'(in_ready_o), 32'd1);
        chk("mid_overflow", 32'(overflow_o), 32'd0);
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b0, '0, 1'b1, 1'b0, l);
            chk("mid_no_stale", 32'(m_axis_tvalid_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
